// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment Avalon writer.
// Segment patterns are active-low: bit0 = seg a .. bit6 = seg g.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } seg7_state_e;

    localparam logic [6:0] SEG7_BLANK      = 7'h7F;
    localparam int         PIO_DATA_OFFSET = 0;

    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment pattern; blank forces all segments off.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_pattern
);

    assign o_pattern = i_blank ? SEG7_BLANK : SEG7_LUT[i_nibble];

endmodule

// File: rtl/seg7_avalon_writer.sv
// Avalon-MM master writing decoded hex digits to a bank of PIO data registers,
// with optional readback compare and per-transfer waitrequest timeout.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_WRITE | avm_write to the current digit's PIO
// ST_READ  | avm_read of the same PIO, compare low 7 bits
// ST_DONE  | one-cycle done pulse
// Index advance happens in the completing WRITE/READ cycle, so there is no
// separate NEXT cycle between digits.
module seg7_avalon_writer
    import seg7_pkg::*;
#(
    parameter int                NUM_DIGITS = 8,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                STRIDE     = 16,
    parameter bit                VERIFY     = 1'b1,
    parameter int                TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [4*NUM_DIGITS-1:0] cmd_value,
    input  logic [NUM_DIGITS-1:0]   cmd_blank,
    output logic                    busy,
    output logic                    done,
    output logic                    err_mismatch,
    output logic                    err_timeout,
    output logic [3:0]              err_digit,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_write,
    output logic                    avm_read,
    output logic [31:0]             avm_writedata,
    input  logic [31:0]             avm_readdata,
    input  logic                    avm_waitrequest
);

    localparam logic [3:0]  LAST_IDX   = 4'(NUM_DIGITS - 1);
    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);

    seg7_state_e r_state;
    seg7_state_e w_state_nxt;

    logic [63:0] r_value;
    logic [15:0] r_blank;
    logic [3:0]  r_idx;
    logic [15:0] r_wait_cnt;
    logic        r_err_mismatch;
    logic        r_err_timeout;
    logic [3:0]  r_err_digit;

    logic [3:0]  w_nibble;
    logic        w_blank;
    logic [6:0]  w_pattern;
    logic        w_xfer;
    logic        w_accept;
    logic        w_last;
    logic        w_timeout;
    logic        w_mismatch;
    logic        w_advance;
    logic        w_unused_rd;

    // Operands padded to 16 digits so the 4-bit index never overruns them.
    assign w_nibble = r_value[{r_idx, 2'b00} +: 4];
    assign w_blank  = r_blank[r_idx];

    seg7_hex_decode u_decode (
        .i_nibble  (w_nibble),
        .i_blank   (w_blank),
        .o_pattern (w_pattern)
    );

    assign w_xfer     = (r_state == ST_WRITE) || (r_state == ST_READ);
    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_timeout  = w_xfer && avm_waitrequest && (r_wait_cnt == 16'd1);
    assign w_mismatch = (r_state == ST_READ) && !avm_waitrequest
                        && (avm_readdata[6:0] != w_pattern);
    assign w_unused_rd = ^avm_readdata[31:7];

    assign avm_address   = w_xfer ? (BASE_ADDR + ADDR_W'(PIO_DATA_OFFSET)
                                     + ADDR_W'(r_idx) * ADDR_W'(STRIDE)) : '0;
    assign avm_writedata = avm_write ? {25'b0, w_pattern} : 32'b0;

    assign err_mismatch = r_err_mismatch;
    assign err_timeout  = r_err_timeout;
    assign err_digit    = r_err_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        avm_write   = 1'b0;
        avm_read    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                avm_write = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (!avm_waitrequest) begin
                    if (VERIFY) begin
                        w_state_nxt = ST_READ;
                    end else if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            ST_READ: begin
                avm_read = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else if (!avm_waitrequest) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WRITE;
                        w_advance   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value        <= '0;
            r_blank        <= '0;
            r_idx          <= '0;
            r_wait_cnt     <= TIMEOUT_LD;
            r_err_mismatch <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_digit    <= '0;
        end else begin
            if (w_accept) begin
                r_value        <= 64'(cmd_value);
                r_blank        <= 16'(cmd_blank);
                r_idx          <= '0;
                r_err_mismatch <= 1'b0;
                r_err_timeout  <= 1'b0;
                r_err_digit    <= '0;
            end else begin
                if (w_advance) r_idx <= r_idx + 4'd1;
                // err_digit keeps the first failing digit of the command
                if (w_mismatch) begin
                    r_err_mismatch <= 1'b1;
                    if (!r_err_mismatch && !r_err_timeout) r_err_digit <= r_idx;
                end
                if (w_timeout) begin
                    r_err_timeout <= 1'b1;
                    if (!r_err_mismatch && !r_err_timeout) r_err_digit <= r_idx;
                end
            end
            if (w_xfer && avm_waitrequest) begin
                r_wait_cnt <= r_wait_cnt - 16'd1;
            end else begin
                r_wait_cnt <= TIMEOUT_LD;
            end
        end
    end

endmodule
